// File: rtl/modexp_ctrl.sv
// modexp_ctrl: square-and-multiply modular exponentiation sequencer.
// Computes result = base^exponent mod modulus, MSB-first over the exponent,
// sharing one external combinational WIDTH x WIDTH multiplier (mul_a/mul_b/mul_p)
// and reducing every 2*WIDTH-bit product with a restoring shift-subtract reducer
// that consumes one product bit per cycle.
// Optional build macro MODEXP_SKIP_LEADING_ZEROS_EN: start the bit loop at the
// highest set exponent bit instead of bit EXP_WIDTH-1.
module modexp_ctrl #(
    parameter int WIDTH     = 6,
    parameter int EXP_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       base,
    input  logic [EXP_WIDTH-1:0]   exponent,
    input  logic [WIDTH-1:0]       modulus,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       result,
    output logic                   error,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [2*WIDTH-1:0]     mul_p
);

    localparam int CW = $clog2(2 * WIDTH);
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BRED, S_SQ, S_SQR, S_MUL, S_MULR, S_FIN
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       n_q, n_d;
    logic [EXP_WIDTH-1:0]   e_q, e_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH-1:0]       r_q, r_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [WIDTH-1:0]       res_q, res_d;

    // One reducer step: shift the next product bit into the partial remainder
    // and subtract n once if it fits. Since rem < n, the shifted value < 2n.
    logic [WIDTH:0]         shifted;
    logic [WIDTH-1:0]       red;
    logic                   last;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    function automatic logic [IW-1:0] msb_idx(input logic [EXP_WIDTH-1:0] e);
        msb_idx = '0;
        for (int k = 0; k < EXP_WIDTH; k++) begin
            if (e[k]) msb_idx = IW'(k);
        end
    endfunction
`endif

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign error  = err_q;
    assign result = res_q;

    // Reducer datapath shared by BRED, SQR and MULR.
    always_comb begin
        shifted = {rem_q, prod_q[2*WIDTH-1]};
        if (shifted >= {1'b0, n_q}) red = WIDTH'(shifted - {1'b0, n_q});
        else                        red = shifted[WIDTH-1:0];
        last = (cnt_q == LAST);
    end

    // Next-state, datapath updates and multiplier operand selection.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        e_d     = e_q;
        b_d     = b_q;
        r_d     = r_q;
        rem_d   = rem_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = err_q;
        res_d   = res_q;
        mul_a   = '0;
        mul_b   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = modulus;
                    e_d     = exponent;
                    r_d     = (modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                    err_d   = 1'b0;
                    prod_d  = {{WIDTH{1'b0}}, base};
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (modulus == '0) ? S_FIN : S_BRED;
                end
            end
            S_BRED, S_SQR, S_MULR: begin
                rem_d  = red;
                prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q + CW'(1);
                if (last) begin
                    cnt_d = '0;
                    if (state_q == S_BRED) begin
                        b_d     = red;
                        idx_d   = IW'(EXP_WIDTH - 1);
                        state_d = S_SQ;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
                        idx_d = msb_idx(e_q);
                        if (e_q == '0) state_d = S_FIN;
`endif
                    end else begin
                        r_d = red;
                        // After the square, a set bit still needs its multiply.
                        if (state_q == S_SQR && e_q[idx_q]) begin
                            state_d = S_MUL;
                        end else if (idx_q == '0) begin
                            state_d = S_FIN;
                        end else begin
                            idx_d   = idx_q - IW'(1);
                            state_d = S_SQ;
                        end
                    end
                end
            end
            S_SQ, S_MUL: begin
                mul_a   = r_q;
                mul_b   = (state_q == S_SQ) ? r_q : b_q;
                prod_d  = mul_p;
                rem_d   = '0;
                cnt_d   = '0;
                state_d = (state_q == S_SQ) ? S_SQR : S_MULR;
            end
            S_FIN: begin
                done_d  = 1'b1;
                err_d   = (n_q == '0);
                res_d   = (n_q == '0) ? '0 : r_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any run without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            e_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            rem_q   <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            e_q     <= e_d;
            b_q     <= b_d;
            r_q     <= r_d;
            rem_q   <= rem_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl with a scoreboard of expected results
// and a cycle-by-cycle schedule of expected multiplier operands.
module tb_modexp_ctrl;

    localparam int W = 6;
    localparam int E = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   base = '0;
    logic [E-1:0]   exponent = '0;
    logic [W-1:0]   modulus = '0;
    logic           busy, done, error;
    logic [W-1:0]   result, mul_a, mul_b;
    logic [2*W-1:0] mul_p;

    assign mul_p = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};

    modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(E)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base),
        .exponent(exponent), .modulus(modulus), .busy(busy), .done(done),
        .result(result), .error(error), .mul_a(mul_a), .mul_b(mul_b),
        .mul_p(mul_p)
    );

    always #5 clk = ~clk;

    typedef struct { int res; int err; int lat; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int sched_a[$];
    int sched_b[$];
    int mon_idx = 0;
    bit mon_on = 1'b0;

    function automatic int popc(input int e);
        int c = 0;
        for (int k = 0; k < E; k++) if ((e >> k) & 1) c++;
        return c;
    endfunction

    function automatic int msb_of(input int e);
        int m = -1;
        for (int k = 0; k < E; k++) if ((e >> k) & 1) m = k;
        return m;
    endfunction

    function automatic int exp_lat(input int e, input int m);
        int bits = E;
        if (m == 0) return 1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        bits = msb_of(e) + 1;
`endif
        return 1 + 2*W + (bits + popc(e)) * (2*W + 1);
    endfunction

    // Build the expected per-cycle multiplier operands and the final residue.
    task automatic build(input int b, input int e, input int m, output int r_fin);
        int r, bb, top;
        sched_a.delete();
        sched_b.delete();
        if (m == 0) begin
            sched_a.push_back(0); sched_b.push_back(0);
            r_fin = 0;
            return;
        end
        r  = (m == 1) ? 0 : 1;
        bb = b % m;
        repeat (2*W) begin sched_a.push_back(0); sched_b.push_back(0); end
        top = E - 1;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
        top = msb_of(e);
`endif
        for (int i = top; i >= 0; i--) begin
            sched_a.push_back(r); sched_b.push_back(r);
            r = (r * r) % m;
            repeat (2*W) begin sched_a.push_back(0); sched_b.push_back(0); end
            if ((e >> i) & 1) begin
                sched_a.push_back(r); sched_b.push_back(bb);
                r = (r * bb) % m;
                repeat (2*W) begin sched_a.push_back(0); sched_b.push_back(0); end
            end
        end
        sched_a.push_back(0); sched_b.push_back(0);
        r_fin = r;
    endtask

    // Push the expectation and pulse start for one cycle.
    task automatic launch(input int b, input int e, input int m, input int exp_res);
        int rf;
        mon_on = 1'b0;
        build(b, e, m, rf);
        sb.push_back('{(exp_res < 0) ? rf : exp_res, (m == 0) ? 1 : 0, exp_lat(e, m)});
        @(negedge clk);
        base = W'(b); exponent = E'(e); modulus = W'(m); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        mon_idx = 0;
        mon_on  = 1'b1;
    endtask

    // Count cycles to done; optionally pulse a spurious start at cycle poke_at.
    task automatic wait_done(input int poke_at, output int lat, output bit busy_ok,
                             output bit to);
        lat = 0; busy_ok = 1'b1; to = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) begin
                to = 1'b0;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (lat == poke_at) begin
                start = 1'b1; base = W'(3); exponent = E'(5); modulus = W'(5);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // Multiplier operands follow the schedule while running, 0 when idle.
    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (mul_a !== W'(sched_a[mon_idx]) || mul_b !== W'(sched_b[mon_idx])) begin
                errors++;
                $display("FAIL mul_ops cycle=%0d got a=%0d b=%0d expected a=%0d b=%0d",
                         mon_idx, mul_a, mul_b, sched_a[mon_idx], sched_b[mon_idx]);
            end
            mon_idx++;
            if (mon_idx >= sched_a.size()) mon_on = 1'b0;
        end else if (rst_n && !busy) begin
            checks++;
            if (mul_a !== '0 || mul_b !== '0) begin
                errors++;
                $display("FAIL mul_idle got a=%0d b=%0d expected 0 0", mul_a, mul_b);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, error, result, mul_a, mul_b} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b res=%0d a=%0d b=%0d expected all 0",
                     busy, done, error, result, mul_a, mul_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_op(input string name, input int poke_at);
        int lat; bit bok, to; exp_t x;
        wait_done(poke_at, lat, bok, to);
        x = sb.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout got no done expected done at %0d", name, x.lat);
            return;
        end
        checks++;
        if (result !== W'(x.res)) begin
            errors++;
            $display("FAIL %s_result got %0d expected %0d", name, result, x.res);
        end
        checks++;
        if (error !== x.err[0]) begin
            errors++;
            $display("FAIL %s_error got %b expected %0d", name, error, x.err);
        end
        checks++;
        if (lat != x.lat) begin
            errors++;
            $display("FAIL %s_latency got %0d expected %0d", name, lat, x.lat);
        end
        checks++;
        if (!bok) begin
            errors++;
            $display("FAIL %s_busy got busy profile wrong expected high until done", name);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse got done=%b expected 0 one cycle later", name, done);
        end
    endtask

    task automatic test_vectors();
        int tb_b[7] = '{7, 13, 4, 40, 5, 0, 63};
        int tb_e[7] = '{3, 7, 13, 1, 0, 5, 63};
        int tb_m[7] = '{33, 33, 33, 33, 33, 33, 61};
        int tb_r[7] = '{13, 7, 31, 7, 1, 0, -1};
        for (int i = 0; i < 7; i++) begin
            launch(tb_b[i], tb_e[i], tb_m[i], tb_r[i]);
            check_op($sformatf("vec%0d", i), 0);
        end
    endtask

    task automatic test_mod_zero();
        launch(9, 5, 0, 0);
        check_op("mod0", 0);
    endtask

    task automatic test_mod_one();
        for (int i = 0; i < 3; i++) begin
            launch(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1, 0);
            check_op($sformatf("mod1_%0d", i), 0);
        end
    endtask

    task automatic test_restart_ignored();
        launch(7, 3, 33, 13);
        check_op("restart", 30);
    endtask

    task automatic test_reset_midrun();
        exp_t x;
        bit saw_done;
        launch(13, 7, 33, 7);
        repeat (30) @(posedge clk);
        mon_on = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, result, mul_a, mul_b} !== '0) begin
            errors++;
            $display("FAIL midrun_reset_outputs got busy=%b done=%b err=%b res=%0d a=%0d b=%0d expected all 0",
                     busy, done, error, result, mul_a, mul_b);
        end
        x = sb.pop_front();
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL midrun_abort got done/busy after reset expected none (aborted res %0d)", x.res);
        end
        launch(4, 13, 33, 31);
        check_op("after_reset", 0);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_mod_zero();
        test_mod_one();
        test_restart_ignored();
        test_reset_midrun();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
